// File: rtl/rf_pkg.sv
// Shared definitions for the 2-read/1-write register file: default geometry,
// the register index type and the helper that decides whether an index names
// a real, writable register.
package rf_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_NUM_REGS = 16;
  localparam int ZERO_IDX     = 0;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;

  // True when idx is an implemented register that is not the hardwired zero.
  // Reads, writes, reservations and busy lookups all share this rule.
  function automatic logic reg_usable(input int unsigned idx,
                                      input int unsigned num_regs,
                                      input logic        zero_reg);
    return (idx < num_regs) && !(zero_reg && (idx == ZERO_IDX));
  endfunction

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Bundle of the register-file access signals: one writeback port, two
// combinational read ports and the issue-side reservation/busy signals.
interface reg_file_2r1w_if
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS
);

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr_a;
  logic [DATA_W-1:0] rdata_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [DATA_W-1:0] rdata_b;
  logic              pend_set;
  logic [ADDR_W-1:0] pend_addr;
  logic              busy_a;
  logic              busy_b;
  logic [NUM_REGS-1:0] pend_vec;

  // Core side: drives addresses, write data and reservations.
  modport master (
    output we, waddr, wdata, raddr_a, raddr_b, pend_set, pend_addr,
    input  rdata_a, rdata_b, busy_a, busy_b, pend_vec
  );

  // Register file side.
  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b, pend_set, pend_addr,
    output rdata_a, rdata_b, busy_a, busy_b, pend_vec
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set when issue reserves a
// destination and cleared when writeback lands. Also answers the per-port
// busy lookups used for RAW hazard detection.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic                pend_set,
  input  logic [ADDR_W-1:0]   pend_addr,
  input  logic [ADDR_W-1:0]   raddr_a,
  input  logic [ADDR_W-1:0]   raddr_b,
  output logic                busy_a,
  output logic                busy_b,
  output logic [NUM_REGS-1:0] pend_vec
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  logic usable_a;
  logic usable_b;
  logic fwd_a;
  logic fwd_b;

  // Decode reservation and writeback into one-hot masks over the registers.
  always_comb begin
    // NOTE: defaulting every combinational output before any condition
    // guarantees no path leaves it unassigned, so no latch is inferred.
    set_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_usable(i, NUM_REGS, ZERO_REG != 0)) begin
        set_mask[i] = pend_set && (pend_addr == ADDR_W'(i));
        clr_mask[i] = we && (waddr == ADDR_W'(i));
      end
    end
  end

  // Clear first, then set: a new producer reserving the register being
  // written back in the same cycle keeps ownership.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: state updates use non-blocking assignments so every flop in the
      // design samples pre-edge values regardless of block ordering.
      pend_q <= '0;
    end else begin
      pend_q <= (pend_q & ~clr_mask) | set_mask;
    end
  end

  // A register being forwarded this cycle is no longer a hazard.
  assign usable_a = reg_usable(32'(raddr_a), NUM_REGS, ZERO_REG != 0);
  assign usable_b = reg_usable(32'(raddr_b), NUM_REGS, ZERO_REG != 0);
  assign fwd_a    = (BYPASS != 0) && we && (waddr == raddr_a);
  assign fwd_b    = (BYPASS != 0) && we && (waddr == raddr_b);

  assign busy_a   = usable_a && !fwd_a && pend_q[raddr_a];
  assign busy_b   = usable_b && !fwd_b && pend_q[raddr_b];
  assign pend_vec = pend_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// General-purpose register file: one synchronous write port, two
// combinational read ports with optional write-to-read bypass, optional
// hardwired zero register and a pending-write scoreboard.
module reg_file_2r1w
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  reg_file_2r1w_if.slave  bus
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rdata [2];
  logic              wr_ok;

  // Writes to unimplemented registers or the hardwired zero are dropped.
  assign wr_ok = bus.we && reg_usable(32'(bus.waddr), NUM_REGS, ZERO_REG != 0);

  // Storage array: synchronous clear and single write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the array is cleared on reset because software relies on a
      // known all-zero register state; this forces flops rather than RAM.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  assign raddr[0] = bus.raddr_a;
  assign raddr[1] = bus.raddr_b;

  // Read muxes: zero for unusable addresses, forwarded data on a same-cycle
  // write hit, stored value otherwise.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = '0;
      if (reg_usable(32'(raddr[p]), NUM_REGS, ZERO_REG != 0)) begin
        if ((BYPASS != 0) && bus.we && (bus.waddr == raddr[p])) begin
          rdata[p] = bus.wdata;
        end else begin
          rdata[p] = regs[raddr[p]];
        end
      end
    end
  end

  assign bus.rdata_a = rdata[0];
  assign bus.rdata_b = rdata[1];

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (bus.we),
    .waddr     (bus.waddr),
    .pend_set  (bus.pend_set),
    .pend_addr (bus.pend_addr),
    .raddr_a   (bus.raddr_a),
    .raddr_b   (bus.raddr_b),
    .busy_a    (bus.busy_a),
    .busy_b    (bus.busy_b),
    .pend_vec  (bus.pend_vec)
  );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w. Two instances share one stimulus stream:
//   cfg 0: 16 regs, no zero register, bypass on
//   cfg 1: 12 regs, zero register, bypass off
// A behavioural model (plain arrays) predicts every output each cycle.
module tb_reg_file_2r1w;
  import rf_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  logic     we;
  reg_idx_t waddr;
  logic [7:0] wdata;
  reg_idx_t raddr_a;
  reg_idx_t raddr_b;
  logic     pend_set;
  reg_idx_t pend_addr;

  always #5 clk = ~clk;

  reg_file_2r1w_if #(.DATA_W(8), .ADDR_W(4), .NUM_REGS(16)) bus0 ();
  reg_file_2r1w_if #(.DATA_W(8), .ADDR_W(4), .NUM_REGS(12)) bus1 ();

  assign bus0.we = we;           assign bus1.we = we;
  assign bus0.waddr = waddr;     assign bus1.waddr = waddr;
  assign bus0.wdata = wdata;     assign bus1.wdata = wdata;
  assign bus0.raddr_a = raddr_a; assign bus1.raddr_a = raddr_a;
  assign bus0.raddr_b = raddr_b; assign bus1.raddr_b = raddr_b;
  assign bus0.pend_set = pend_set;   assign bus1.pend_set = pend_set;
  assign bus0.pend_addr = pend_addr; assign bus1.pend_addr = pend_addr;

  reg_file_2r1w #(.DATA_W(8), .ADDR_W(4), .NUM_REGS(16), .ZERO_REG(0), .BYPASS(1))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  reg_file_2r1w #(.DATA_W(8), .ADDR_W(4), .NUM_REGS(12), .ZERO_REG(1), .BYPASS(0))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int nr(int c); return (c == 0) ? 16 : 12; endfunction
  function automatic bit zr(int c); return c == 1; endfunction
  function automatic bit bp(int c); return c == 0; endfunction

  logic [7:0]  m_regs [2][16];
  logic [15:0] m_pend [2];

  function automatic bit usable(int c, reg_idx_t a);
    return (int'(a) < nr(c)) && !(zr(c) && a == 4'd0);
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        for (int r = 0; r < 16; r++) m_regs[c][r] <= 8'h00;
        m_pend[c] <= 16'h0000;
      end else begin
        if (we && usable(c, waddr)) begin
          m_regs[c][waddr] <= wdata;
          m_pend[c][waddr] <= 1'b0;
        end
        if (pend_set && usable(c, pend_addr)) m_pend[c][pend_addr] <= 1'b1;
      end
    end
  end

  function automatic logic [7:0] exp_rd(int c, reg_idx_t a);
    if (!usable(c, a)) return 8'h00;
    if (bp(c) && we && waddr == a) return wdata;
    return m_regs[c][a];
  endfunction

  function automatic logic exp_busy(int c, reg_idx_t a);
    if (!usable(c, a)) return 1'b0;
    if (bp(c) && we && waddr == a) return 1'b0;
    return m_pend[c][a];
  endfunction

  task automatic cmp_cfg(input int c, input logic [7:0] ra, input logic [7:0] rb,
                         input logic ba, input logic bb, input logic [15:0] pv);
    check($sformatf("c%0d_rdata_a", c), 32'(ra), 32'(exp_rd(c, raddr_a)));
    check($sformatf("c%0d_rdata_b", c), 32'(rb), 32'(exp_rd(c, raddr_b)));
    check($sformatf("c%0d_busy_a", c),  32'(ba), 32'(exp_busy(c, raddr_a)));
    check($sformatf("c%0d_busy_b", c),  32'(bb), 32'(exp_busy(c, raddr_b)));
    check($sformatf("c%0d_pend_vec", c), 32'(pv), 32'(m_pend[c]));
  endtask

  bit cmp_en = 1'b0;

  // Every cycle out of reset, both instances are checked against the model.
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      cmp_cfg(0, bus0.rdata_a, bus0.rdata_b, bus0.busy_a, bus0.busy_b, bus0.pend_vec);
      cmp_cfg(1, bus1.rdata_a, bus1.rdata_b, bus1.busy_a, bus1.busy_b, 16'(bus1.pend_vec));
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0;
    pend_set = 1'b0;
  endtask

  // ---------------- directed then random stimulus ----------------
  initial begin
    rst_n = 1'b0; we = 1'b1; waddr = 4'd3; wdata = 8'hAA;
    raddr_a = 4'd3; raddr_b = 4'd0; pend_set = 1'b1; pend_addr = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; idle(); cmp_en = 1'b1;
    @(negedge clk);
    check("rst_rdata_a_c0", 32'(bus0.rdata_a), 32'h00);
    check("rst_pend_vec_c0", 32'(bus0.pend_vec), 32'h0);
    check("rst_pend_vec_c1", 32'(bus1.pend_vec), 32'h0);

    // Plain write then read on both ports.
    next(); we = 1'b1; waddr = 4'd7; wdata = 8'h5C;
    next(); idle(); raddr_a = 4'd7; raddr_b = 4'd7;
    @(negedge clk);
    check("wr_rdata_a_c0", 32'(bus0.rdata_a), 32'h5C);
    check("wr_rdata_b_c0", 32'(bus0.rdata_b), 32'h5C);
    check("wr_rdata_a_c1", 32'(bus1.rdata_a), 32'h5C);
    next(); raddr_a = 4'd3;
    @(negedge clk);
    check("other_reg_c0", 32'(bus0.rdata_a), 32'h00);

    // Same-cycle bypass.
    next(); we = 1'b1; waddr = 4'd4; wdata = 8'h91; raddr_b = 4'd4;
    @(negedge clk);
    check("bypass_c0", 32'(bus0.rdata_b), 32'h91);
    check("nobypass_c1", 32'(bus1.rdata_b), 32'h00);

    // Register 0: write plus reservation.
    next(); we = 1'b1; waddr = 4'd0; wdata = 8'hFF; pend_set = 1'b1; pend_addr = 4'd0;
    next(); idle(); raddr_a = 4'd0;
    @(negedge clk);
    check("zero_rdata_c1", 32'(bus1.rdata_a), 32'h00);
    check("zero_busy_c1", 32'(bus1.busy_a), 32'h0);
    check("zero_pend0_c1", 32'(bus1.pend_vec[0]), 32'h0);
    check("r0_rdata_c0", 32'(bus0.rdata_a), 32'hFF);
    check("r0_pend0_c0", 32'(bus0.pend_vec[0]), 32'h1);

    // Scoreboard set, busy, writeback clear, set-wins collision.
    next(); pend_set = 1'b1; pend_addr = 4'd5;
    next(); idle(); raddr_a = 4'd5;
    @(negedge clk);
    check("busy5_c0", 32'(bus0.busy_a), 32'h1);
    check("busy5_c1", 32'(bus1.busy_a), 32'h1);
    next(); we = 1'b1; waddr = 4'd5; wdata = 8'h21;
    @(negedge clk);
    check("busy5_fwd_c0", 32'(bus0.busy_a), 32'h0);
    check("busy5_nofwd_c1", 32'(bus1.busy_a), 32'h1);
    check("rd5_fwd_c0", 32'(bus0.rdata_a), 32'h21);
    next(); idle();
    @(negedge clk);
    check("pend5_clr_c0", 32'(bus0.pend_vec[5]), 32'h0);
    check("pend5_clr_c1", 32'(bus1.pend_vec[5]), 32'h0);
    next(); we = 1'b1; waddr = 4'd5; wdata = 8'h42; pend_set = 1'b1; pend_addr = 4'd5;
    next(); idle();
    @(negedge clk);
    check("pend5_setwin_c0", 32'(bus0.pend_vec[5]), 32'h1);
    check("pend5_setwin_c1", 32'(bus1.pend_vec[5]), 32'h1);
    check("rd5_collide_c1", 32'(bus1.rdata_a), 32'h42);

    // Address beyond the 12-register depth.
    next(); we = 1'b1; waddr = 4'd14; wdata = 8'h33; pend_set = 1'b1; pend_addr = 4'd14;
    next(); idle(); raddr_a = 4'd14; raddr_b = 4'd7;
    @(negedge clk);
    check("oob_rdata_c1", 32'(bus1.rdata_a), 32'h00);
    check("oob_busy_c1", 32'(bus1.busy_a), 32'h0);
    check("oob_pend_vec_c1", 32'(bus1.pend_vec), 32'h020);
    check("oob_r7_c1", 32'(bus1.rdata_b), 32'h5C);
    check("r14_rdata_c0", 32'(bus0.rdata_a), 32'h33);
    check("pend_vec_c0", 32'(bus0.pend_vec), 32'h4021);

    // Random traffic with occasional mid-stream resets.
    for (int n = 0; n < 3000; n++) begin
      next();
      rst_n     = ($urandom_range(63) != 0);
      we        = 1'($urandom_range(1));
      waddr     = 4'($urandom_range(15));
      wdata     = 8'($urandom_range(255));
      raddr_a   = 4'($urandom_range(15));
      raddr_b   = 4'($urandom_range(15));
      pend_set  = ($urandom_range(2) == 0);
      pend_addr = 4'($urandom_range(15));
      if ($urandom_range(3) == 0) raddr_a = waddr;
      if ($urandom_range(3) == 0) raddr_b = pend_addr;
    end
    next();
    rst_n = 1'b1; idle();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
